uart_tx_framer: RTL
===================

Name: uart_tx_framer

Overview:
- Serial UART transmitter for the wave_gen response path.
- Takes bytes from the response/character buffer over a valid/ready handshake and serialises them onto txd_pin.
- Frame format: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Its output is the line the UART monitor/response checker decodes at BAUD_RATE.

Parameters:
- CLOCK_RATE, 27_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2 only).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit, sampled on accept.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  block can accept a byte this cycle.
- txd_pin  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress (any state except IDLE).

Behaviour:
- One clock; reset is synchronous and active-high; no other clock domains.
- Bit period: DIV = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE, integer-rounded. Defaults give DIV = 234.
  - Baud counter is 16 bits; counts 0..DIV-1 and restarts at 0 on every state entry.
  - Elaboration error if DIV < 2 or STOP_BITS is not 1 or 2.
- Reset values: txd_pin = 1, tx_ready = 0 during reset, tx_busy = 0, state = IDLE, counters = 0.
  - tx_ready rises the first cycle after reset deasserts.
- Reset asserted mid-frame aborts the frame immediately. txd_pin = 1 on the next edge; the byte is discarded, not resent.
- tx_ready = 1 only in IDLE (and not in reset). Accept = tx_valid & tx_ready.
  - On accept, tx_data is latched into the shift register and the state moves to START.
  - tx_data/tx_valid are don't-care outside accept.
- States:
  - IDLE: txd_pin = 1.
  - START: txd_pin = 0 for DIV clocks.
  - DATA: bit index 0..7, txd_pin = shift[0]; shift right each DIV clocks; after bit 7, go to PARITY if PARITY != 0, else STOP.
  - PARITY: txd_pin = ^data for even, ~^data for odd; DIV clocks.
  - STOP: txd_pin = 1 for STOP_BITS*DIV clocks, then IDLE.
- txd_pin is registered; no glitches.
- Timing: txd_pin falls on the edge after the accept edge. Each bit lasts exactly DIV clocks.
- Frame length: (10 + (PARITY != 0) + (STOP_BITS - 1)) * DIV clocks.
- Back-to-back: with tx_valid held high, IDLE lasts exactly 1 clock between frames. Minimum start-to-start spacing is frame length + 1 clock.
- tx_valid high during reset is not accepted. The first accept is possible in the first cycle after reset.
- tx_busy = 1 from the cycle after accept through the last STOP clock; 0 in IDLE.

Test Plan:
- Reset, then single byte 0x55, defaults -> txd_pin low 234 clks, then bits 1,0,1,0,1,0,1,0 at 234 clks each, high 234 clks; monitor reports 0x55; tx_ready returns 2340 clks after txd_pin falls, plus 1.
- Back-to-back 0x00, 0xFF, 0xA5 with tx_valid held high -> three correct frames; start edges exactly 2341 clks apart; tx_busy low for exactly 1 clk between frames.
- PARITY=2, then PARITY=1, STOP_BITS=2, byte 0x07 -> even: parity bit 1, frame 2574 clks; odd: parity bit 0, stop high for 468 clks, frame 2808 clks.
- Assert reset for 1 clk during DATA bit 3 of 0xC3 -> txd_pin = 1 on the next edge; tx_busy = 0; tx_ready = 1 one clk after reset drops; next byte 0x3C sent cleanly and decoded correctly.
- tx_valid high throughout reset (20 clks) with 0x41 -> no line activity during reset; byte accepted in the first post-reset cycle; monitor receives 0x41 ('A').
- CLOCK_RATE=100_000_000, BAUD_RATE=115_200 -> DIV = 868; byte 0x0D received by a BAUD_RATE monitor without framing error.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Accepts one byte per frame over a valid/ready handshake; txd_pin is registered.
module uart_tx_framer #(
    parameter int CLOCK_RATE = 27_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd_pin,
    output logic       tx_busy
);
    localparam int unsigned DIV       = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    if (DIV < 2 || DIV > 65536) begin : g_bad_div
        $error("uart_tx_framer: bit period DIV must be in 2..65536");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_stop;
    logic        r_txd;
    logic        r_busy;

    state_t      w_state_next;
    logic [15:0] w_cnt_next;
    logic [2:0]  w_bit_next;
    logic [7:0]  w_shift_next;
    logic        w_par_next;
    logic        w_stop_next;
    logic        w_txd_next;
    logic        w_busy_next;
    logic        w_bit_end;
    logic        w_accept;

    assign tx_ready = (r_state == S_IDLE) & ~reset;
    assign txd_pin  = r_txd;
    assign tx_busy  = r_busy;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_stop_next  = r_stop;
        w_bit_end    = (r_cnt == DIV_LAST);
        w_accept     = tx_valid & tx_ready;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_accept) begin
                    w_shift_next = tx_data;
                    w_par_next   = (PARITY == 2) ? ^tx_data : ~^tx_data;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_stop_next  = 1'b0;
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_stop_next  = 1'b0;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_stop == STOP_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_next = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so txd_pin changes on the same edge.
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
            S_PARITY: w_txd_next = w_par_next;
            default:  w_txd_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_stop  <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_stop  <= w_stop_next;
            r_txd   <= w_txd_next;
            r_busy  <= w_busy_next;
        end
    end
endmodule
